pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Fetch/execute sequencer that sits directly upstream of the control decoder.
//   Owns the state flop, the instruction register (IR) and the program counter (PC).
//   Feeds state and opcode to the decoder, and applies the decoder's IL/PS strobes on the next edge.
//   Also owns a return-address stack. Call (opcode 4'b1101) pushes and jumps; return (PS=2'b11) pops.
// PARAMETERS
//   PC_W    8   PC and return-stack entry width; PC wraps modulo 2^PC_W
//   IR_W   16   instruction width; opcode = IR[IR_W-1 -: 4]
//   OFF_W   6   branch/jump offset width; offset = IR[OFF_W-1:0], two's complement
//   DEPTH   4   return-stack entries (power of 2, >=2)
// PORTS
//   clk       in   1                 rising-edge clock
//   rst       in   1                 synchronous, active-high reset
//   mem_data  in   IR_W              instruction word read at address pc
//   IL        in   1                 instruction load strobe from decoder
//   PS        in   2                 PC select: 00 hold, 01 +1, 10 +offset, 11 pop/return
//   state     out  1                 0 = fetch, 1 = execute
//   opcode    out  4                 IR[IR_W-1 -: 4], to decoder
//   ir        out  IR_W              full instruction register
//   pc        out  PC_W              program counter / fetch address
//   sp        out  $clog2(DEPTH)+1   stack occupancy, 0..DEPTH
//   ovf       out  1                 sticky: push attempted while full
//   udf       out  1                 sticky: pop attempted while empty
// BEHAVIOUR
//   Reset (rst=1 at edge): state=0, ir=0, pc=0, sp=0, ovf=0, udf=0. Stack contents are don't-care.
//     Reset wins over all other inputs, including mid-instruction.
//   state toggles every clock: fetch -> execute -> fetch. Each instruction takes exactly 2 cycles.
//   Fetch edge (state=0):
//     IL=1 -> ir <= mem_data; IL=0 -> ir holds.
//     PS ignored; pc holds.
//   Execute edge (state=1):
//     ir holds.
//     call = (opcode==4'b1101); off = sign-extended ir[OFF_W-1:0] to PC_W bits.
//   Execute, call=1 (overrides PS):
//     pc <= pc + off.
//     If sp<DEPTH: push pc+1, sp++.
//     If sp==DEPTH: no push, ovf <= 1; jump still taken.
//   Execute, call=0:
//     PS=00: pc holds.
//     PS=01: pc <= pc+1.
//     PS=10: pc <= pc+off.
//     PS=11, sp>0: pc <= top-of-stack, sp--.
//     PS=11, sp==0: pc <= pc+1, udf <= 1.
//   Arithmetic: all PC sums are truncated to PC_W bits. 8'hFF+1 -> 8'h00; 8'h02+(-3) -> 8'hFF.
//   Stack is LIFO; the top entry is index sp-1. Push and pop never occur in the same cycle.
//   ovf and udf clear only on rst.
//   All outputs are registered; no combinational path from any input to any output.
// TESTING
//   1. Reset then run 3 straight-line instructions (PS=01, IL=1 in fetch):
//      pc 0->1->2->3; ir tracks mem_data; state alternates 0,1.
//   2. pc=8'h10, ir=16'hB03E (offset -2), PS=10 in execute -> pc=8'h0E.
//      Same case with PS=01 -> pc=8'h11.
//   3. Call at pc=8'h20 with offset +5 (ir=16'hD005) -> pc=8'h25, sp=1.
//      Later PS=11 -> pc=8'h21, sp=0.
//   4. DEPTH=4: nest 5 calls -> sp stays 4, ovf=1.
//      Then 4 returns unwind in LIFO order; 5th return -> pc+1, udf=1.
//   5. pc=8'hFF, PS=01 -> pc=8'h00. pc=8'h01 with offset -4 -> pc=8'hFD.
//   6. Assert rst during execute after 2 pushes -> next cycle all outputs are zero; fetch resumes at pc=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer: state flop, IR, PC and return-address stack.
// Decoder strobes IL/PS are applied on the edge that follows their phase.
module pc_sequencer #(
    parameter int PC_W  = 8,
    parameter int IR_W  = 16,
    parameter int OFF_W = 6,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [IR_W-1:0]            mem_data,
    input  logic                       IL,
    input  logic [1:0]                 PS,
    output logic                       state,
    output logic [3:0]                 opcode,
    output logic [IR_W-1:0]            ir,
    output logic [PC_W-1:0]            pc,
    output logic [$clog2(DEPTH):0]     sp,
    output logic                       ovf,
    output logic                       udf
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int SP_W  = IDX_W + 1;
    localparam logic [3:0] OP_CALL = 4'b1101;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IR_W-1:0]     ir_q, ir_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;
    logic [PC_W-1:0]     stack_q [DEPTH];

    logic                call;
    logic                full;
    logic                empty;
    logic                push;
    logic [PC_W-1:0]     off;
    logic [PC_W-1:0]     pc_inc;
    logic [PC_W-1:0]     pc_off;
    logic [IDX_W-1:0]    push_idx;
    logic [IDX_W-1:0]    top_idx;
    logic [PC_W-1:0]     tos;

    assign call     = (ir_q[IR_W-1 -: 4] == OP_CALL);
    assign full     = (sp_q == SP_W'(DEPTH));
    assign empty    = (sp_q == '0);
    assign off      = PC_W'($signed(ir_q[OFF_W-1:0]));
    assign pc_inc   = pc_q + PC_W'(1);
    assign pc_off   = pc_q + off;
    assign push_idx = sp_q[IDX_W-1:0];
    assign top_idx  = sp_q[IDX_W-1:0] - IDX_W'(1);
    assign tos      = stack_q[top_idx];

    // Next-state, IR/PC/stack-pointer update and sticky flag logic.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        push    = 1'b0;
        unique case (state_q)
            FETCH: begin
                state_d = EXEC;
                if (IL) begin
                    ir_d = mem_data;
                end
            end
            EXEC: begin
                state_d = FETCH;
                unique case (1'b1)
                    call: begin
                        pc_d = pc_off;
                        if (full) begin
                            ovf_d = 1'b1;
                        end else begin
                            push = 1'b1;
                            sp_d = sp_q + SP_W'(1);
                        end
                    end
                    (!call && PS == 2'b00): pc_d = pc_q;
                    (!call && PS == 2'b01): pc_d = pc_inc;
                    (!call && PS == 2'b10): pc_d = pc_off;
                    (!call && PS == 2'b11): begin
                        if (empty) begin
                            pc_d  = pc_inc;
                            udf_d = 1'b1;
                        end else begin
                            pc_d = tos;
                            sp_d = sp_q - SP_W'(1);
                        end
                    end
                    default: pc_d = pc_q;
                endcase
            end
            default: state_d = FETCH;
        endcase
    end

    // Architectural registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            ir_q    <= '0;
            pc_q    <= '0;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Return-address storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign state  = state_q;
    assign opcode = ir_q[IR_W-1 -: 4];
    assign ir     = ir_q;
    assign pc     = pc_q;
    assign sp     = sp_q;
    assign ovf    = ovf_q;
    assign udf    = udf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer.
// Hand-computed expectations checked with immediate assertions.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic [15:0] mem_data;
    logic        IL;
    logic [1:0]  PS;
    logic        state;
    logic [3:0]  opcode;
    logic [15:0] ir;
    logic [7:0]  pc;
    logic [2:0]  sp;
    logic        ovf;
    logic        udf;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .mem_data (mem_data),
        .IL       (IL),
        .PS       (PS),
        .state    (state),
        .opcode   (opcode),
        .ir       (ir),
        .pc       (pc),
        .sp       (sp),
        .ovf      (ovf),
        .udf      (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Fetch phase; PS is driven to a non-hold value to show it is ignored.
    task automatic fetch(input logic [15:0] m, input logic il);
        mem_data = m;
        IL       = il;
        PS       = 2'b01;
        tick();
    endtask

    task automatic execute(input logic [1:0] ps);
        mem_data = 16'hDEAD;
        IL       = 1'b1;
        PS       = ps;
        tick();
    endtask

    task automatic instr(input logic [15:0] m, input logic [1:0] ps);
        fetch(m, 1'b1);
        execute(ps);
    endtask

    initial begin
        rst      = 1'b1;
        mem_data = 16'h0;
        IL       = 1'b0;
        PS       = 2'b00;
        tick();
        chk("rst_state", state, 0);
        chk("rst_ir", ir, 0);
        chk("rst_pc", pc, 0);
        chk("rst_sp", sp, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_udf", udf, 0);
        rst = 1'b0;

        fetch(16'h1111, 1'b1);
        chk("t1_state_f", state, 1);
        chk("t1_ir0", ir, 16'h1111);
        chk("t1_pc_f", pc, 8'h00);
        execute(2'b01);
        chk("t1_state_e", state, 0);
        chk("t1_pc1", pc, 8'h01);
        chk("t1_ir_hold", ir, 16'h1111);
        fetch(16'h2222, 1'b1);
        chk("t1_ir1", ir, 16'h2222);
        chk("t1_opcode", opcode, 4'h2);
        execute(2'b01);
        chk("t1_pc2", pc, 8'h02);
        instr(16'h3333, 2'b01);
        chk("t1_pc3", pc, 8'h03);
        chk("t1_ir2", ir, 16'h3333);

        fetch(16'hFFFF, 1'b0);
        chk("il0_hold", ir, 16'h3333);
        execute(2'b00);
        chk("ps00_hold", pc, 8'h03);

        instr(16'hB00D, 2'b10);
        chk("t2_pc10", pc, 8'h10);
        instr(16'hB03E, 2'b10);
        chk("t2_branch_neg", pc, 8'h0E);
        instr(16'hB002, 2'b10);
        chk("t2_pc10b", pc, 8'h10);
        instr(16'hB03E, 2'b01);
        chk("t2_inc", pc, 8'h11);

        instr(16'hB00F, 2'b10);
        chk("t3_pc20", pc, 8'h20);
        instr(16'hD005, 2'b00);
        chk("t3_call_pc", pc, 8'h25);
        chk("t3_call_sp", sp, 1);
        instr(16'h0000, 2'b01);
        chk("t3_pc26", pc, 8'h26);
        instr(16'h0000, 2'b11);
        chk("t3_ret_pc", pc, 8'h21);
        chk("t3_ret_sp", sp, 0);

        instr(16'hD001, 2'b11);
        instr(16'hD002, 2'b11);
        instr(16'hD003, 2'b11);
        instr(16'hD004, 2'b11);
        chk("t4_pc_4", pc, 8'h2B);
        chk("t4_sp_4", sp, 4);
        chk("t4_ovf_0", ovf, 0);
        instr(16'hD005, 2'b11);
        chk("t4_pc_5", pc, 8'h30);
        chk("t4_sp_full", sp, 4);
        chk("t4_ovf", ovf, 1);
        instr(16'h0000, 2'b11);
        chk("t4_ret1", pc, 8'h28);
        chk("t4_sp3", sp, 3);
        instr(16'h0000, 2'b11);
        chk("t4_ret2", pc, 8'h25);
        instr(16'h0000, 2'b11);
        chk("t4_ret3", pc, 8'h23);
        instr(16'h0000, 2'b11);
        chk("t4_ret4", pc, 8'h22);
        chk("t4_sp0", sp, 0);
        chk("t4_udf_0", udf, 0);
        instr(16'h0000, 2'b11);
        chk("t4_ret5_pc", pc, 8'h23);
        chk("t4_udf", udf, 1);
        chk("t4_sp_empty", sp, 0);
        chk("t4_ovf_sticky", ovf, 1);

        instr(16'hB020, 2'b10);
        chk("t5_pc03", pc, 8'h03);
        instr(16'hB03C, 2'b10);
        chk("t5_pcFF", pc, 8'hFF);
        instr(16'h0000, 2'b01);
        chk("t5_wrap", pc, 8'h00);
        instr(16'h0000, 2'b01);
        instr(16'hB03C, 2'b10);
        chk("t5_neg_wrap", pc, 8'hFD);

        instr(16'hD001, 2'b00);
        instr(16'hD001, 2'b00);
        chk("t6_pc", pc, 8'hFF);
        chk("t6_sp2", sp, 2);
        fetch(16'hD005, 1'b1);
        chk("t6_state_e", state, 1);
        rst = 1'b1;
        PS  = 2'b11;
        tick();
        rst = 1'b0;
        chk("t6_state", state, 0);
        chk("t6_ir", ir, 0);
        chk("t6_opcode", opcode, 0);
        chk("t6_pc", pc, 0);
        chk("t6_sp", sp, 0);
        chk("t6_ovf", ovf, 0);
        chk("t6_udf", udf, 0);
        fetch(16'h1234, 1'b1);
        chk("t6_ir_after", ir, 16'h1234);
        chk("t6_pc_fetch", pc, 0);
        execute(2'b01);
        chk("t6_pc_after", pc, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
